// File: rtl/jtag_vreg_bank.sv
// Virtual-JTAG data-register bank in the tck domain: IDENT/ADDR/RDATA/WDATA/FLAGS/STATUS
// plus BYPASS, with a shared auto-incrementing address and a one-cycle write strobe.
module jtag_vreg_bank #(
    parameter int                   DR_LENGTH   = 32,
    parameter int                   IR_LENGTH   = 4,
    parameter int                   ADDR_WIDTH  = 10,
    parameter logic [DR_LENGTH-1:0] IDENT_VALUE = 32'h4A544731,
    parameter logic [IR_LENGTH-1:0] IIDENT      = 1,
    parameter logic [IR_LENGTH-1:0] IADDR       = 2,
    parameter logic [IR_LENGTH-1:0] IRDATA      = 3,
    parameter logic [IR_LENGTH-1:0] IWDATA      = 4,
    parameter logic [IR_LENGTH-1:0] IFLAGS      = 5,
    parameter logic [IR_LENGTH-1:0] ISTATUS     = 6
) (
    input  logic                  tck,
    input  logic                  rst,
    input  logic                  tdi,
    output logic                  tdo,
    input  logic [IR_LENGTH-1:0]  ir,
    input  logic                  capture_dr,
    input  logic                  shift_dr,
    input  logic                  update_dr,
    input  logic [DR_LENGTH-1:0]  rdata_in,
    output logic [DR_LENGTH-1:0]  wdata_out,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  wram_enable,
    output logic [DR_LENGTH-1:0]  flags_out
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    logic [DR_LENGTH-1:0]  r_sr;
    logic                  r_bypass;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_autoinc;
    logic [DR_LENGTH-1:0]  r_wdata;
    logic [DR_LENGTH-1:0]  r_flags;
    logic                  r_wen;
    logic [15:0]           r_wcount;
    logic                  r_armed;

    logic w_sel_ident, w_sel_addr, w_sel_rdata, w_sel_wdata, w_sel_flags, w_sel_status;
    logic w_sel_bypass;
    logic w_upd;
    logic w_inc;
    logic [DR_LENGTH-1:0] w_cap;

    always_comb begin
        w_sel_ident  = (ir == IIDENT);
        w_sel_addr   = (ir == IADDR);
        w_sel_rdata  = (ir == IRDATA);
        w_sel_wdata  = (ir == IWDATA);
        w_sel_flags  = (ir == IFLAGS);
        w_sel_status = (ir == ISTATUS);
        w_sel_bypass = !(w_sel_ident | w_sel_addr | w_sel_rdata |
                         w_sel_wdata | w_sel_flags | w_sel_status);
    end

    always_comb begin
        w_cap = '0;
        if (w_sel_ident) begin
            w_cap = IDENT_VALUE;
        end else if (w_sel_addr) begin
            w_cap[DR_LENGTH-1]  = r_autoinc;
            w_cap[ADDR_WIDTH-1:0] = r_addr;
        end else if (w_sel_rdata) begin
            w_cap = rdata_in;
        end else if (w_sel_wdata) begin
            w_cap = r_wdata;
        end else if (w_sel_flags) begin
            w_cap = r_flags;
        end else if (w_sel_status) begin
            w_cap[DR_LENGTH-1] = r_autoinc;
            w_cap[15:0]        = r_wcount;
        end
    end

    // Update only acts on a scan that began with a capture since the last reset,
    // so a reset mid-scan cannot produce a strobe or a register load.
    assign w_upd = update_dr & ~capture_dr & ~shift_dr & r_armed;
    assign w_inc = r_autoinc & ((w_upd & w_sel_rdata) | r_wen);

    assign tdo         = w_sel_bypass ? r_bypass : r_sr[0];
    assign wdata_out   = r_wdata;
    assign addr_out    = r_addr;
    assign wram_enable = r_wen;
    assign flags_out   = r_flags;

    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            r_sr     <= '0;
            r_bypass <= 1'b0;
            r_armed  <= 1'b0;
        end else if (capture_dr) begin
            r_sr     <= w_cap;
            r_bypass <= 1'b0;
            r_armed  <= 1'b1;
        end else if (shift_dr) begin
            r_sr     <= {tdi, r_sr[DR_LENGTH-1:1]};
            r_bypass <= tdi;
        end else if (w_upd) begin
            r_armed  <= 1'b0;
        end
    end

    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            r_addr    <= '0;
            r_autoinc <= 1'b0;
            r_wdata   <= '0;
            r_flags   <= '0;
            r_wen     <= 1'b0;
            r_wcount  <= '0;
        end else begin
            r_wen <= w_upd & w_sel_wdata;
            // An explicit ADDR load takes precedence over any pending increment.
            if (w_upd & w_sel_addr) begin
                r_addr    <= r_sr[ADDR_WIDTH-1:0];
                r_autoinc <= r_sr[DR_LENGTH-1];
            end else if (w_inc) begin
                r_addr    <= r_addr + ADDR_ONE;
            end
            if (w_upd & w_sel_wdata)
                r_wdata <= r_sr;
            if (w_upd & w_sel_flags)
                r_flags <= r_sr;
            if (w_upd & w_sel_status)
                r_wcount <= '0;
            else if (r_wen)
                r_wcount <= r_wcount + 16'd1;
        end
    end

endmodule
